// File: rtl/ldmx_trig_dma_framer_if.sv
// AXI-Stream link from the trigger framer toward the inbound DMA.
// Master drives the beat fields; the slave returns tReady.
interface ldmx_trig_dma_framer_if;
    logic        tValid;
    logic [63:0] tData;
    logic [7:0]  tKeep;
    logic        tLast;
    logic [7:0]  tDest;
    logic        tReady;

    modport master (
        output tValid,
        output tData,
        output tKeep,
        output tLast,
        output tDest,
        input  tReady
    );

    modport slave (
        input  tValid,
        input  tData,
        input  tKeep,
        input  tLast,
        input  tDest,
        output tReady
    );
endinterface

// File: rtl/ldmx_trig_dma_framer.sv
// Trigger-record framer: timestamps accepted triggers, queues
// {spill, event, timestamp} records and emits each one as a two-beat
// AXI-Stream frame (header beat, timestamp beat).
//
// A record stays counted in the FIFO until its last beat is accepted.
// The in-flight frame therefore occupies a slot, and busy/full reflect
// every record not yet delivered downstream.
module ldmx_trig_dma_framer #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned BUSY_THRESH = 12,
    parameter logic [7:0]  TDEST       = 8'h00
) (
    input  logic                          dmaClk,
    input  logic                          dmaRst,
    input  logic                          enable,
    input  logic                          trigger,
    input  logic                          spill,
    ldmx_trig_dma_framer_if.master        dmaIb,
    output logic                          busy,
    output logic [31:0]                   eventCount,
    output logic [15:0]                   dropCount
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_BUSY = (AW+1)'(BUSY_THRESH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef struct packed {
        logic [15:0] spill_num;
        logic [31:0] event_num;
        logic [47:0] ts;
    } rec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        TS   = 2'd2
    } state_t;

    // Header beat layout: marker byte, reserved byte, spill, event.
    function automatic logic [63:0] hdr_beat(input rec_t r);
        return {8'hE5, 8'h00, r.spill_num, r.event_num};
    endfunction

    // Timestamp beat layout: zero-padded 48-bit timestamp.
    function automatic logic [63:0] ts_beat(input logic [47:0] ts);
        return {16'h0000, ts};
    endfunction

    // Counters
    logic [47:0] ts_q;
    logic [15:0] spill_q, spill_d;
    logic [31:0] evt_q, evt_d, evt_base_s;
    logic [15:0] drop_q, drop_d;

    // FIFO
    rec_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt_s;
    logic [AW:0]   cnt_q;
    logic          avail_q;
    logic          busy_q;
    rec_t          rec_s, head_s, next_s;
    logic          trig_en_s, full_s, push_s, drop_s, retire_s;

    // Output stage / FSM
    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [63:0]   data_q, data_d;
    logic [47:0]   tsh_q, tsh_d;

    // Trigger/spill bookkeeping: spill applies before a same-cycle trigger.
    always_comb begin
        trig_en_s  = trigger && enable;
        full_s     = (cnt_q == CNT_FULL);
        push_s     = trig_en_s && !full_s;
        drop_s     = trig_en_s && full_s;
        if (spill) begin
            spill_d    = spill_q + 16'd1;
            evt_base_s = 32'd0;
        end else begin
            spill_d    = spill_q;
            evt_base_s = evt_q;
        end
        if (trig_en_s) begin
            evt_d = evt_base_s + 32'd1;
        end else begin
            evt_d = evt_base_s;
        end
        if (drop_s && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
        rec_s.spill_num = spill_d;
        rec_s.event_num = evt_base_s;
        rec_s.ts        = ts_q;
        rd_nxt_s        = rd_ptr_q + PTR_ONE;
        head_s          = mem_q[rd_ptr_q];
        next_s          = mem_q[rd_nxt_s];
    end

    // Free-running timestamp and event/spill/drop counters.
    always_ff @(posedge dmaClk) begin
        if (dmaRst) begin
            ts_q    <= 48'd0;
            spill_q <= 16'd0;
            evt_q   <= 32'd0;
            drop_q  <= 16'd0;
        end else begin
            ts_q    <= ts_q + 48'd1;
            spill_q <= spill_d;
            evt_q   <= evt_d;
            drop_q  <= drop_d;
        end
    end

    // Record storage; contents need no reset since pointers gate reads.
    always_ff @(posedge dmaClk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= rec_s;
        end
    end

    // FIFO pointers, occupancy and the occupancy-derived flags.
    // avail_q gives freshly written records one cycle to settle before
    // the idle FSM picks them up.
    always_ff @(posedge dmaClk) begin
        if (dmaRst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= CNT_ZERO;
            avail_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (retire_s) begin
                rd_ptr_q <= rd_nxt_s;
            end
            case ({push_s, retire_s})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
            avail_q <= (cnt_q != CNT_ZERO);
            busy_q  <= (cnt_q >= CNT_BUSY);
        end
    end

    // Frame sequencing and next values for the registered beat outputs.
    always_comb begin
        state_d  = state_q;
        retire_s = 1'b0;
        valid_d  = valid_q;
        last_d   = last_q;
        data_d   = data_q;
        tsh_d    = tsh_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (avail_q && (cnt_q != CNT_ZERO)) begin
                    state_d = HDR;
                    valid_d = 1'b1;
                    data_d  = hdr_beat(head_s);
                    tsh_d   = head_s.ts;
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                if (dmaIb.tReady) begin
                    state_d = TS;
                    data_d  = ts_beat(tsh_q);
                    last_d  = 1'b1;
                end else begin
                    state_d = HDR;
                end
            end
            TS: begin
                if (dmaIb.tReady) begin
                    retire_s = 1'b1;
                    if (cnt_q > CNT_ONE) begin
                        state_d = HDR;
                        data_d  = hdr_beat(next_s);
                        tsh_d   = next_s.ts;
                        last_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end else begin
                    state_d = TS;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // FSM state and registered beat outputs.
    always_ff @(posedge dmaClk) begin
        if (dmaRst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= 64'd0;
            tsh_q   <= 48'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            tsh_q   <= tsh_d;
        end
    end

    assign dmaIb.tValid = valid_q;
    assign dmaIb.tData  = data_q;
    assign dmaIb.tLast  = last_q;
    assign dmaIb.tKeep  = 8'hFF;
    assign dmaIb.tDest  = TDEST;
    assign busy         = busy_q;
    assign eventCount   = evt_q;
    assign dropCount    = drop_q;

endmodule
